// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl -- bit-serial sequencer around a single my1BitALUv2 slice.
//
// Executes one WIDTH-bit operation over WIDTH clock cycles, feeding the
// operands LSB-first through the 1-bit slice and registering the ripple
// carry between cycles. Result and flags appear together with a one-cycle
// done pulse and hold until the next completed operation.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 request pulse, sampled only in IDLE
//   opcode[2:0]           0 AND, 1 OR, 2 ADD, 3 SUB, 4 NOR, 5 NAND, 6 ANDN, 7 ORN
//   a, b [WIDTH-1:0]      operands, captured on the accepting edge
//   abort                 (only with SERIAL_ALU_ABORT_EN) cancel a running op
//   busy                  high in RUN and DONE
//   done                  one-cycle pulse; result/flags valid from here on
//   result[WIDTH-1:0]     final result
//   carryOut, overflow    ADD/SUB flags, 0 for logic ops
//   zero                  result == 0
//
// Optional feature macro: SERIAL_ALU_ABORT_EN (adds the abort input).

// 1-bit ALU slice: optional input inversion, then AND / OR / full-add.
module my1BitALUv2 (
    input  logic       a,
    input  logic       b,
    input  logic       carryIn,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic [1:0] op,
    output logic       carryOut,
    output logic       result
);
    logic aa, bb;

    always_comb begin
        aa       = a ^ ainvert;
        bb       = b ^ binvert;
        carryOut = (aa & bb) | (aa & carryIn) | (bb & carryIn);
        case (op)
            2'd0:    result = aa & bb;
            2'd1:    result = aa | bb;
            2'd2:    result = aa ^ bb ^ carryIn;
            default: result = 1'b0;  // set-less-than input is not used here
        endcase
    end
endmodule

module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ALU_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_sr_q, res_sr_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;  // carry into the MSB, for overflow
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;

    // Opcode decode to slice controls
    logic       ainv, binv, is_arith;
    logic [1:0] sop;
    logic       slice_co, slice_res;

    always_comb begin
        ainv     = 1'b0;
        binv     = 1'b0;
        sop      = 2'd0;
        is_arith = 1'b0;
        case (op_q)
            3'd0: sop = 2'd0;
            3'd1: sop = 2'd1;
            3'd2: begin sop = 2'd2; is_arith = 1'b1; end
            3'd3: begin sop = 2'd2; binv = 1'b1; is_arith = 1'b1; end
            3'd4: begin sop = 2'd0; ainv = 1'b1; binv = 1'b1; end
            3'd5: begin sop = 2'd1; ainv = 1'b1; binv = 1'b1; end
            3'd6: begin sop = 2'd0; binv = 1'b1; end
            default: begin sop = 2'd1; binv = 1'b1; end
        endcase
    end

    my1BitALUv2 u_slice (
        .a        (a_sr_q[0]),
        .b        (b_sr_q[0]),
        .carryIn  (carry_q),
        .ainvert  (ainv),
        .binvert  (binv),
        .op       (sop),
        .carryOut (slice_co),
        .result   (slice_res)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cmsb_d   = cmsb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    op_d    = opcode;
                    cnt_d   = '0;
                    carry_d = (opcode == 3'd3);  // SUB: +1 completes two's complement
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef SERIAL_ALU_ABORT_EN
                if (abort) begin
                    state_d = IDLE;
                end else
`endif
                begin
                    a_sr_d   = a_sr_q >> 1;
                    b_sr_d   = b_sr_q >> 1;
                    res_sr_d = {slice_res, res_sr_q[WIDTH-1:1]};
                    carry_d  = slice_co;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cmsb_d  = carry_q;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                result_d = res_sr_q;
                cout_d   = is_arith & carry_q;
                ovf_d    = is_arith & (cmsb_q ^ carry_q);
                zero_d   = (res_sr_q == '0);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cmsb_q   <= cmsb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign carryOut = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
module tb_serial_alu_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   opcode = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, carryOut, overflow, zero;
    logic [W-1:0] result;
`ifdef SERIAL_ALU_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
`ifdef SERIAL_ALU_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryOut (carryOut),
        .overflow (overflow),
        .zero     (zero)
    );

    // Issue one operation and return the number of negedges from the
    // accepting edge until done is seen (-1 on timeout). Inputs are
    // scrambled right after acceptance to prove they were captured.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] aa, bb,
                          output int lat);
        @(negedge clk);
        opcode = op; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        opcode = 3'($urandom); a = W'($urandom); b = W'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, result, carryOut, overflow, zero} !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b result=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, carryOut, overflow, zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arith;
        // {op, a, b, result, c, v, z}
        logic [2:0]   ops [6] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3};
        logic [W-1:0] av  [6] = '{8'h0F, 8'h7F, 8'hFF, 8'h05, 8'h80, 8'h33};
        logic [W-1:0] bv  [6] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01, 8'h33};
        logic [W-1:0] rv  [6] = '{8'h10, 8'h80, 8'h00, 8'hFE, 8'h7F, 8'h00};
        logic [2:0]   fv  [6] = '{3'b000, 3'b010, 3'b101, 3'b000, 3'b110, 3'b101};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], av[i], bv[i], lat);
            checks++;
            if (lat !== W + 2) begin
                failures++;
                $display("FAIL arith%0d latency: got %0d, required %0d", i, lat, W + 2);
            end
            checks++;
            if ({result, carryOut, overflow, zero} !== {rv[i], fv[i]}) begin
                failures++;
                $display("FAIL arith%0d op=%0d %h,%h: result=%h cvz=%b%b%b, required %h cvz=%b",
                         i, ops[i], av[i], bv[i], result, carryOut, overflow, zero, rv[i], fv[i]);
            end
            if (i == 0) begin
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || result !== 8'h10) begin
                    failures++;
                    $display("FAIL done_pulse: done=%b result=%h, required done=0 result=10",
                             done, result);
                end
            end
        end
    endtask

    task automatic test_logic;
        logic [2:0]   ops [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [W-1:0] rv  [6] = '{8'h88, 8'hEE, 8'h11, 8'h77, 8'h44, 8'hDD};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], 8'hCC, 8'hAA, lat);
            checks++;
            if (lat !== W + 2 || {result, carryOut, overflow, zero} !== {rv[i], 3'b000}) begin
                failures++;
                $display("FAIL logic op=%0d: lat=%0d result=%h cvz=%b%b%b, required lat=%0d %h cvz=000",
                         ops[i], lat, result, carryOut, overflow, zero, W + 2, rv[i]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int dones = 0;
        logic [W-1:0] r = '0;
        @(negedge clk);
        opcode = 3'd2; a = 8'h20; b = 8'h05; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (done) begin dones++; r = result; end
            start = (k == 2 || k == 4);  // sampled on RUN cycles 3 and 5
            a = 8'hFF; b = 8'hFF; opcode = 3'd3;
        end
        start = 1'b0;
        checks++;
        if (dones !== 1 || r !== 8'h25) begin
            failures++;
            $display("FAIL start_while_busy: dones=%0d result=%h, required 1 and 25", dones, r);
        end
    endtask

    task automatic test_reset_mid_run;
        int dones = 0;
        int lat;
        @(negedge clk);
        opcode = 3'd2; a = 8'h11; b = 8'h22; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, carryOut, overflow, zero} !== '0) begin
            failures++;
            $display("FAIL reset_mid_run: busy=%b done=%b result=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, carryOut, overflow, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_no_done: dones=%0d, required 0", dones);
        end
        run_op(3'd2, 8'h03, 8'h04, lat);
        checks++;
        if (lat !== W + 2 || result !== 8'h07) begin
            failures++;
            $display("FAIL after_reset: lat=%0d result=%h, required %0d and 07", lat, result, W + 2);
        end
    endtask

`ifdef SERIAL_ALU_ABORT_EN
    task automatic test_abort;
        int dones = 0;
        int lat;
        run_op(3'd2, 8'h0F, 8'h01, lat);
        @(negedge clk);
        opcode = 3'd2; a = 8'h40; b = 8'h40; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;  // sampled on RUN cycle 4
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy: busy=%b, required 0", busy);
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || result !== 8'h10) begin
            failures++;
            $display("FAIL abort_hold: dones=%0d result=%h, required 0 and 10", dones, result);
        end
        run_op(3'd2, 8'h01, 8'h01, lat);
        checks++;
        if (lat !== W + 2 || result !== 8'h02) begin
            failures++;
            $display("FAIL after_abort: lat=%0d result=%h, required %0d and 02", lat, result, W + 2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_start_while_busy();
        test_reset_mid_run();
`ifdef SERIAL_ALU_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
Bit-serial sequencer that drives one my1BitALUv2 slice (a, b, carryIn, ainvert, binvert, op[1:0] -> carryOut, result) over WIDTH clock cycles to execute a full WIDTH-bit operation.
- Decodes an opcode into the slice's ainvert/binvert/op/initial-carry controls.
- Shifts operands LSB-first through the slice and registers the ripple carry between cycles.
- Assembles the result and flags, and reports completion with a start/busy/done handshake.
- Reuses the existing 1-bit slice as the shared arithmetic resource, instantiated inside this block.

Parameters:
WIDTH, 8, operand/result width in bits; legal values are 2 to 64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
opcode  input  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 NOR (~a&~b), 5 NAND (~a|~b), 6 ANDN (a&~b), 7 ORN (a|~b)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result and flags are valid from this cycle on
result  output  WIDTH  final result, held until the next accepted start
carryOut  output  1  carry out of the MSB for ADD/SUB; 0 for logic ops
overflow  output  1  signed overflow for ADD/SUB; 0 for logic ops
zero  output  1  high when result == 0; valid with done

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; counter is 0; carry register is 0.
  - Outputs busy, done, result, carryOut, overflow and zero are all 0.
  - Reset during RUN discards the operation; no done is produced.
- State machine with three states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture a, b and opcode into shift registers and clear the counter.
  - Load the carry register with 1 for SUB, 0 otherwise.
  - Go to RUN.
- Decode to slice controls:
  - AND: op=0, no inversion. OR: op=1, no inversion. ADD: op=2, no inversion.
  - SUB: op=2, binvert=1, carry-in 1.
  - NOR: op=0, ainvert=1, binvert=1. NAND: op=1, ainvert=1, binvert=1.
  - ANDN: op=0, binvert=1. ORN: op=1, binvert=1.
- RUN (one bit per cycle):
  - Slice inputs are bit 0 of each operand shift register plus the carry register.
  - Slice result shifts into the MSB of the result shift register; the operand registers shift right.
  - Carry register takes the slice carryOut; the counter increments.
  - Before the final (MSB) bit, save the carry register as the carry into the MSB.
  - After WIDTH bit-cycles, go to DONE.
- DONE (one cycle):
  - Drive result from the result shift register.
  - carryOut = carry register.
  - overflow = carry into MSB XOR carry register.
  - Force carryOut and overflow to 0 for logic opcodes.
  - zero = (result == 0). done=1, then go to IDLE.
- Latency:
  - An accepted start at edge N gives done high in the cycle after edge N+WIDTH+1.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- start while busy=1 is ignored; nothing is queued.
- Inputs a, b and opcode may change freely after the accepting edge.
- result and flags hold their DONE values through IDLE until the next DONE.
- Internal-only registers update during RUN; the visible outputs never show partial values.
- Counter wrap never occurs: the counter is wide enough for WIDTH and is cleared on every start.

Optional Feature:
SERIAL_ALU_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 in RUN returns the FSM to IDLE on the next edge; no done.
  - Outputs keep their previous completed values.
  - abort in IDLE or DONE has no effect. abort has priority over completing the last bit.
- Undefined: the abort port is absent and every accepted operation runs to DONE.

Test Plan:
- ADD 8'h0F + 8'h01 -> result 8'h10, carryOut 0, overflow 0, zero 0; done exactly WIDTH+2 cycles after the start edge.
- ADD 8'h7F + 8'h01 -> 8'h80, overflow 1, carryOut 0. ADD 8'hFF + 8'h01 -> 8'h00, carryOut 1, zero 1, overflow 0.
- SUB 8'h05 - 8'h07 -> 8'hFE, carryOut 0, overflow 0. SUB 8'h80 - 8'h01 -> 8'h7F, carryOut 1, overflow 1. SUB 8'h33 - 8'h33 -> 8'h00, zero 1, carryOut 1.
- Logic ops with a=8'hCC, b=8'hAA:
  - AND -> 8'h88, OR -> 8'hEE, NOR -> 8'h11, NAND -> 8'h77, ANDN -> 8'h44, ORN -> 8'hDD.
  - carryOut and overflow are 0 for all six.
- start pulsed on cycles 3 and 5 of an ADD -> only one done; result is from the first operands. Deassert rst_n mid-RUN -> all outputs 0 at once, no done, next start runs normally.
- SERIAL_ALU_ABORT_EN: abort in RUN cycle 4 -> no done, previous result retained, busy low next cycle. A following ADD 8'h01 + 8'h01 -> 8'h02.
